// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; byte 0 of each word is the MSB.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic        clear,
    input  logic        last,
    input  logic [7:0]  data,
    output logic        word_valid_c,
    output logic [31:0] word_c
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx;
    logic [31:0]      acc;
    logic [31:0]      lane_c;

    // Unfilled low bytes stay zero because acc is cleared after every word.
    always_comb begin
        lane_c       = {24'b0, data} << {~idx, 3'b000};
        word_c       = acc | lane_c;
        word_valid_c = accept & (last | (idx == IDX_W'(BYTES_PER_WORD - 1)));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            if (word_valid_c) begin
                idx <= '0;
                acc <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
                acc <= word_c;
            end
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Streams a program into instruction memory word by word and holds the core
// stalled until the final word has landed.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-2:0] word_count,
    output logic              cpu_run,
    output logic              load_done,
    output logic              error
);

    localparam int unsigned PTR_W = ADDR_W - 2;
    localparam int unsigned CNT_W = ADDR_W - 1;
    localparam int unsigned WORDS = 2 ** PTR_W;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic             full_c;
    logic             accept_c;
    logic             overflow_c;
    logic             begin_c;
    logic             word_valid_c;
    logic [31:0]      word_c;

    // A byte arriving with memory already full is an overflow and never reaches the packer.
    assign full_c     = (word_count == CNT_W'(WORDS));
    assign accept_c   = in_valid & in_ready & ~full_c;
    assign overflow_c = in_valid & in_ready & full_c;
    assign begin_c    = start & ((state == IDLE) | (state == DONE));

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .accept       (accept_c),
        .clear        (begin_c),
        .last         (in_last),
        .data         (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            wr_ptr     <= '0;
            cpu_run    <= 1'b0;
            load_done  <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (begin_c) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        word_count <= '0;
                        wr_ptr     <= '0;
                        cpu_run    <= 1'b0;
                        load_done  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (overflow_c) begin
                        state    <= ERROR;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                    end else if (word_valid_c) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= {wr_ptr, 2'b00};
                        mem_wdata  <= word_c;
                        wr_ptr     <= wr_ptr + PTR_W'(1);
                        word_count <= word_count + CNT_W'(1);
                        if (in_last) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                // One cycle of slack so cpu_run rises only after the last write.
                FLUSH: begin
                    state     <= DONE;
                    cpu_run   <= 1'b1;
                    load_done <= 1'b1;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: packing, completion timing, overflow, reset and restart.
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  word_count;
    logic        cpu_run;
    logic        load_done;
    logic        error;

    int          checks = 0;
    int          passed = 0;
    int          ready_drops = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];

    imem_stream_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write log: captures the pre-edge value of each one-cycle write strobe.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte, optionally after idle cycles; returns at the negedge before the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            if (in_ready !== 1'b1) ready_drops++;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL handshake_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, mem_we, cpu_run, load_done, error} !== 5'b0)
            $display("FAIL reset_flags: got %b, required 00000", {in_ready, mem_we, cpu_run, load_done, error});
        else passed++;
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 32'h0)
            $display("FAIL reset_bus: addr %h data %h, required 00 00000000", mem_addr, mem_wdata);
        else passed++;
        checks++;
        if (word_count !== 7'd0) $display("FAIL reset_count: got %0d, required 0", word_count);
        else passed++;
    endtask

    task automatic test_basic();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1) $display("FAIL basic_ready: got %b, required 1", in_ready);
        else passed++;
        for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7, 0);
        end_stream();
        checks++;
        if (mem_we !== 1'b1 || load_done !== 1'b0 || cpu_run !== 1'b0)
            $display("FAIL basic_flush: we %b done %b run %b, required 1 0 0", mem_we, load_done, cpu_run);
        else passed++;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || cpu_run !== 1'b1)
            $display("FAIL basic_done: done %b run %b, required 1 1", load_done, cpu_run);
        else passed++;
        checks++;
        if (wa_q.size() != 2 || wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00010203)
            $display("FAIL basic_word0: n %0d addr %h data %h, required 2 00 00010203", wa_q.size(), wa_q[0], wd_q[0]);
        else passed++;
        checks++;
        if (wa_q[1] !== 8'h04 || wd_q[1] !== 32'h04050607)
            $display("FAIL basic_word1: addr %h data %h, required 04 04050607", wa_q[1], wd_q[1]);
        else passed++;
        checks++;
        if (word_count !== 7'd2) $display("FAIL basic_count: got %0d, required 2", word_count);
        else passed++;
    endtask

    task automatic test_partial();
        logic [7:0] b[6];
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(b[i], i == 5, 0);
        end_stream();
        @(negedge clk);
        checks++;
        if (wa_q.size() != 2 || wd_q[0] !== 32'hAABBCCDD)
            $display("FAIL partial_word0: n %0d data %h, required 2 aabbccdd", wa_q.size(), wd_q[0]);
        else passed++;
        checks++;
        if (wa_q[1] !== 8'h04 || wd_q[1] !== 32'h11220000)
            $display("FAIL partial_zero_fill: addr %h data %h, required 04 11220000", wa_q[1], wd_q[1]);
        else passed++;
        checks++;
        if (load_done !== 1'b1 || word_count !== 7'd2)
            $display("FAIL partial_done: done %b count %0d, required 1 2", load_done, word_count);
        else passed++;
    endtask

    task automatic test_full();
        logic [31:0] exp;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        for (int i = 0; i < 256; i++) send_byte(8'(i), i == 255, 0);
        end_stream();
        @(negedge clk);
        checks++;
        if (wa_q.size() != 64) $display("FAIL full_writes: got %0d, required 64", wa_q.size());
        else passed++;
        for (int w = 0; w < 64; w++) begin
            exp = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            checks++;
            if (wa_q[w] !== 8'(4*w) || wd_q[w] !== exp)
                $display("FAIL full_word%0d: addr %h data %h, required %h %h", w, wa_q[w], wd_q[w], 8'(4*w), exp);
            else passed++;
        end
        checks++;
        if (word_count !== 7'd64 || load_done !== 1'b1 || error !== 1'b0)
            $display("FAIL full_done: count %0d done %b err %b, required 64 1 0", word_count, load_done, error);
        else passed++;
    endtask

    task automatic test_overflow();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0, 0);
        send_byte(8'hEE, 1'b1, 0);
        end_stream();
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_run !== 1'b0 || load_done !== 1'b0)
            $display("FAIL ovf_state: err %b rdy %b run %b done %b, required 1 0 0 0", error, in_ready, cpu_run, load_done);
        else passed++;
        pulse_start();
        @(negedge clk);
        checks++;
        if (wa_q.size() != 64 || mem_we !== 1'b0)
            $display("FAIL ovf_no_write: writes %0d we %b, required 64 0", wa_q.size(), mem_we);
        else passed++;
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL ovf_sticky: err %b rdy %b, required 1 0", error, in_ready);
        else passed++;
    endtask

    task automatic test_reset_midload();
        logic [7:0] b[4];
        b = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_reset();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i), 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({in_ready, mem_we, cpu_run, load_done, error} !== 5'b0 || word_count !== 7'd0)
            $display("FAIL midreset_outputs: flags %b count %0d, required 00000 0",
                     {in_ready, mem_we, cpu_run, load_done, error}, word_count);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() != 0 || in_ready !== 1'b0)
            $display("FAIL midreset_no_write: writes %0d rdy %b, required 0 0", wa_q.size(), in_ready);
        else passed++;
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(b[i], i == 3, 0);
        end_stream();
        @(negedge clk);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 32'h12345678)
            $display("FAIL midreset_reload: n %0d addr %h data %h, required 1 00 12345678", wa_q.size(), wa_q[0], wd_q[0]);
        else passed++;
    endtask

    task automatic test_restart();
        logic [7:0] b[4];
        b = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        wa_q.delete(); wd_q.delete();
        @(negedge clk);
        checks++;
        if (cpu_run !== 1'b1 || word_count !== 7'd1)
            $display("FAIL restart_pre: run %b count %0d, required 1 1", cpu_run, word_count);
        else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cpu_run !== 1'b0 || load_done !== 1'b0 || word_count !== 7'd0 || in_ready !== 1'b1)
            $display("FAIL restart_leave: run %b done %b count %0d rdy %b, required 0 0 0 1",
                     cpu_run, load_done, word_count, in_ready);
        else passed++;
        for (int i = 0; i < 4; i++) send_byte(b[i], i == 3, 0);
        end_stream();
        @(negedge clk);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 32'h9ABCDEF0)
            $display("FAIL restart_write: n %0d addr %h data %h, required 1 00 9abcdef0", wa_q.size(), wa_q[0], wd_q[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        wa_q.delete(); wd_q.delete();
        ready_drops = 0;
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(8'(8'h30 + i), i == 11, int'($urandom_range(0, 2)));
        end_stream();
        @(negedge clk);
        checks++;
        if (wa_q.size() != 3 || wd_q[0] !== 32'h30313233 || wd_q[1] !== 32'h34353637 || wd_q[2] !== 32'h38393A3B)
            $display("FAIL gappy_words: n %0d data %h %h %h, required 3 30313233 34353637 38393a3b",
                     wa_q.size(), wd_q[0], wd_q[1], wd_q[2]);
        else passed++;
        checks++;
        if (wa_q[2] !== 8'h08 || word_count !== 7'd3)
            $display("FAIL gappy_addr: addr %h count %0d, required 08 3", wa_q[2], word_count);
        else passed++;
        checks++;
        if (ready_drops != 0) $display("FAIL gappy_ready: in_ready low %0d times in LOAD, required 0", ready_drops);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_full();
        test_overflow();
        test_reset_midload();
        test_restart();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Loads a program into the 256-byte instruction memory that the single-cycle core fetches from via PC[7:0].
- Accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words.
- Writes each word to sequential word-aligned addresses.
- Holds the core stalled until the load completes, then raises cpu_run to enable PC update.

Parameters:
ADDR_W, 8, byte-address width of instruction memory (capacity 2^ADDR_W bytes)
WORDS, 2^(ADDR_W-2), derived; word capacity (64 at default)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin a new load
in_valid  in  1  stream byte valid
in_data  in  8  stream byte
in_last  in  1  marks final byte; qualified by in_valid
in_ready  out  1  loader accepts byte this cycle
mem_we  out  1  instruction-memory write strobe, one cycle per word
mem_addr  out  ADDR_W  byte address of write, bits[1:0] always 0
mem_wdata  out  32  word to write
word_count  out  ADDR_W-1  words written in current load, 0..WORDS
cpu_run  out  1  high only in DONE; gates PC register enable
load_done  out  1  high in DONE
error  out  1  high in ERROR (overflow)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; in_ready, mem_we, cpu_run, load_done, error = 0; mem_addr, mem_wdata, word_count = 0; byte index 0; accumulator 0.
- States: IDLE, LOAD, FLUSH, DONE, ERROR.
- IDLE: in_ready=0. start -> LOAD. Entering LOAD clears word_count, byte index, accumulator and the write pointer.
- LOAD: in_ready=1. A byte is accepted when in_valid & in_ready.
  - Byte k of a word (k=0..3) lands in bits [31-8k:24-8k]; byte 0 is the MSB.
  - After byte 3 is accepted at cycle t: mem_we=1 at t+1, mem_addr = 4*word_count (pre-increment), mem_wdata = packed word. word_count increments at t+1.
  - Back-to-back acceptance continues with no bubble.
- in_last accepted with byte k:
  - The word is written at t+1 exactly as above. If k<3, the unfilled low bytes are zero.
  - State goes to FLUSH at t+1 and to DONE at t+2, so cpu_run rises only after the final write has landed.
- Overflow: a byte accepted when word_count==WORDS goes to ERROR next cycle. That byte causes no write.
  - Exactly WORDS*4 bytes with in_last on the final byte completes normally.
  - in_last on an overflowing byte also goes to ERROR.
- FLUSH: in_ready=0. Unconditional -> DONE.
- DONE: cpu_run=1, load_done=1, in_ready=0. start -> LOAD; cpu_run falls the same cycle the state leaves DONE. word_count holds its final value.
- ERROR: error=1, in_ready=0, cpu_run=0. Only reset exits.
- start in LOAD or FLUSH is ignored. start in ERROR is ignored.
- in_valid outside LOAD is ignored; no handshake occurs.
- reset mid-load: returns to IDLE next edge. The partial word is discarded and no write is issued. mem_we is 0 in the cycle after reset is sampled.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Arithmetic: the write pointer is a word index of width ADDR_W-2; mem_addr = {index, 2'b00}. word_count is one bit wider so it can reach WORDS without wrap.

Decomposition:
- Shared package imem_loader_pkg holds:
  - state enum (IDLE, LOAD, FLUSH, DONE, ERROR);
  - default ADDR_W = 8;
  - constant BYTES_PER_WORD = 4.
- Sub-module byte_packer: 2-bit byte index plus 32-bit accumulator.
  - Inputs: accept, clear, last, data.
  - Outputs: word_valid pulse and packed word with zero-fill.
  - The top level owns the FSM, pointer, count and handshake.

Test Plan:
- reset, start, stream 8 bytes 00 01 02 03 04 05 06 07 with in_last on the 8th byte.
  - Writes: mem_we at addr 0x00 data 0x00010203, then addr 0x04 data 0x04050607.
  - word_count=2; load_done and cpu_run rise 2 cycles after the last accept.
- Stream 6 bytes AA BB CC DD 11 22, in_last on 0x22.
  - Second write: addr 0x04 data 0x11220000; then DONE.
- Stream 256 bytes, in_last on the 256th.
  - 64 writes; final addr 0xFC; word_count=64; DONE, error=0.
  - Repeat with a 257th byte and no in_last on byte 256: ERROR, error=1, no write for byte 257, in_ready=0.
- Assert reset after 3 bytes accepted.
  - No mem_we ever, state IDLE, all outputs 0.
  - start then 4 bytes 12 34 56 78 with last: write addr 0x00 data 0x12345678.
- In DONE, pulse start: cpu_run falls that cycle, word_count=0. New load writes from addr 0x00.
- Toggle in_valid randomly during a 12-byte load: same 3 writes as with continuous valid. in_ready stays high throughout LOAD.
